iter_muldiv: RTL and testbench
==============================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO width (even, >= 8).
REQ-002 clk  input  1  system clock, all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising clk edge.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 x  input  WIDTH  operand 1 (multiplicand / dividend / MTHI-MTLO data).
REQ-007 y  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 busy  output  1  high while a multiply/divide is in progress.
REQ-009 done  output  1  one-cycle pulse marking HI/LO updated by a multiply/divide.
REQ-010 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011 lo  output  WIDTH  LO register (product lower half / quotient).
REQ-012 div_by_zero  output  1  registered flag; set by a zero-divisor DIV/DIVU, held until next accepted multiply/divide.

Function
REQ-013 FSM states: IDLE, CALC, FIX; busy = (state != IDLE).
REQ-014 Accept = start high in IDLE at an edge; x, y, op captured into internal registers at that edge; later changes to x/y/op do not affect the operation.
REQ-015 MULT/MULTU/DIV/DIVU accept: IDLE -> CALC, iteration counter cleared to 0.
REQ-016 CALC: one iteration per cycle (shift-add multiply, restoring divide on magnitudes); after exactly WIDTH cycles, CALC -> FIX.
REQ-017 FIX: sign correction applied, hi/lo written, done = 1 for that single cycle, FIX -> IDLE.
REQ-018 Latency: accept at edge N -> hi/lo updated and done high after edge N+WIDTH+1, busy low in that same cycle.
REQ-019 hi/lo hold previous values throughout CALC; partial results live only in internal registers.
REQ-020 MULT: signed 2*WIDTH-bit product {hi,lo}; MULTU: unsigned product.
REQ-021 DIV: quotient truncated toward zero; remainder carries dividend sign; |remainder| < |divisor|.
REQ-022 DIVU: unsigned quotient in lo, remainder in hi.
REQ-023 DIV of most-negative value by -1: lo = most-negative value, hi = 0; no flag.
REQ-024 Divide by zero (y = 0, DIV or DIVU): full WIDTH+1-cycle latency kept; lo = all ones, hi = captured x, div_by_zero = 1 at the done cycle.
REQ-025 div_by_zero cleared at accept of any MULT/MULTU/DIV/DIVU; unchanged by MTHI/MTLO.
REQ-026 MTHI/MTLO accepted in IDLE: hi (resp. lo) <= x at that edge; state stays IDLE; no busy, no done.
REQ-027 start while busy ignored entirely (no capture, no queueing, HI/LO unaffected).
REQ-028 op 110/111 with start: no state or register change.
REQ-029 start held high continuously: a new request is accepted at the first edge in IDLE after done (edge N+WIDTH+2 for back-to-back).

Reset
REQ-030 rst high forces asynchronously: state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0.
REQ-031 rst during CALC/FIX aborts the operation; no done pulse; hi/lo = 0 after reset.
REQ-032 First accept possible at first rising edge with rst low.

Verification (WIDTH = 32)
REQ-033 MULT x=0xFFFFFFFF y=0x00000002 -> after 33 cycles hi=0xFFFFFFFF lo=0xFFFFFFFE, done pulse 1 cycle, busy high exactly 33 cycles.
REQ-034 MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-035 DIV x=0xFFFFFFF9 (-7) y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV x=0x80000000 y=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU x=100 y=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; following MULTU 3*5 -> div_by_zero=0 at accept, lo=15, hi=0.
REQ-037 DIVU 100/7 started, start+MTLO x=0x1234 pulsed at cycle 10, then rst at cycle 20 -> MTLO ignored, no done, hi=lo=0, busy=0 immediately.
REQ-038 MTHI x=0xA5A5A5A5 then MTLO x=0x5A5A5A5A in consecutive cycles -> hi/lo updated on those edges, busy/done stay low.

Source files
------------

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iter_muldiv
// Description : Iterative HI/LO multiply/divide unit (one bit per cycle).
// Revision    : 1.0
// ============================================================================
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic             sx_d;
  logic             sy_d;
  logic [WIDTH-1:0] ax_d;
  logic [WIDTH-1:0] ay_d;

  // Operands are reduced to magnitudes; signs are reapplied in FIX.
  always_comb begin
    sx_d = ~op_i[0] & x_i[WIDTH-1];
    sy_d = ~op_i[0] & y_i[WIDTH-1];
    ax_d = sx_d ? -x_i : x_i;
    ay_d = sy_d ? -y_i : y_i;
  end

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   shl_d;
  logic [WIDTH:0]   sub_d;
  logic [WIDTH-1:0] it_hi_d;
  logic [WIDTH-1:0] it_lo_d;

  // acc_lo holds the multiplier (shifted out LSB first) or the dividend/quotient.
  always_comb begin
    sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shl_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
    sub_d = shl_d - {1'b0, b_q};
    if (is_div_q) begin
      if (sub_d[WIDTH]) begin
        it_hi_d = shl_d[WIDTH-1:0];
        it_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
        it_hi_d = sub_d[WIDTH-1:0];
        it_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      it_hi_d = sum_d[WIDTH:1];
      it_lo_d = {sum_d[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;

  always_comb begin
    prod_d = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    if (!is_div_q) begin
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end else if (dz_q) begin
      fix_hi_d = x_q;
      fix_lo_d = '1;
    end else begin
      fix_hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
      fix_lo_d = neg_q ? -acc_lo_q : acc_lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      x_q       <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (!op_i[2]) begin
              state_q   <= CALC;
              cnt_q     <= '0;
              is_div_q  <= op_i[1];
              neg_q     <= sx_d ^ sy_d;
              rem_neg_q <= sx_d;
              dz_q      <= (y_i == '0);
              dbz_q     <= 1'b0;
              x_q       <= x_i;
              acc_hi_q  <= '0;
              acc_lo_q  <= op_i[1] ? ax_d : ay_d;
              b_q       <= op_i[1] ? ay_d : ax_d;
            end else if (op_i[1:0] == 2'b00) begin
              hi_q <= x_i;
            end else if (op_i[1:0] == 2'b01) begin
              lo_q <= x_i;
            end
          end
        end
        CALC: begin
          acc_hi_q <= it_hi_d;
          acc_lo_q <= it_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          dbz_q   <= is_div_q & dz_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_muldiv
// Description : Directed plus randomized self-checking bench for iter_muldiv.
// Revision    : 1.0
// ============================================================================
module tb_iter_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbz;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic         m_dz;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .op_i         (op),
    .x_i          (x),
    .y_i          (y),
    .busy_o       (busy),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    z  = 1'b0;
    p  = '0;
    h  = '0;
    l  = '0;
    case (o)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == '0) begin
          z = 1'b1; l = '1; h = a;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = W'(ua / ub); h = W'(ua % ub);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_arith(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
    logic [W-1:0] eh, el;
    logic         ez;
    int           cyc;
    bit           hold_ok;
    model(o, a, b, eh, el, ez);
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; op = 3'($urandom);
    chk({tag, "/busy_at_accept"}, busy, 1);
    chk({tag, "/dbz_cleared"}, dbz, 0);
    hold_ok = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "/latency"}, cyc, W + 1);
    chk({tag, "/hold_busy"}, hold_ok, 1);
    chk({tag, "/hi"}, hi, eh);
    chk({tag, "/lo"}, lo, el);
    chk({tag, "/dbz"}, dbz, ez);
    chk({tag, "/busy_at_done"}, busy, 0);
    m_hi = eh; m_lo = el; m_dz = ez;
    @(posedge clk); #1;
    chk({tag, "/done_one_cycle"}, done, 0);
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [W-1:0] a, input string tag);
    start = 1'b1; op = o; x = a; y = $urandom;
    @(posedge clk); #1;
    if (o == 3'd4) m_hi = a;
    else if (o == 3'd5) m_lo = a;
    chk({tag, "/hi"}, hi, m_hi);
    chk({tag, "/lo"}, lo, m_lo);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/dbz"}, dbz, m_dz);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    #3;
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/hi", hi, 0);
    chk("reset/lo", lo, 0);
    chk("reset/dbz", dbz, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_arith(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
    chk("mult/hi_const", hi, 32'hFFFF_FFFF);
    chk("mult/lo_const", lo, 32'hFFFF_FFFE);
    do_arith(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
    chk("multu/hi_const", hi, 32'h0000_0001);
    do_arith(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7");
    chk("div_neg7/lo_const", lo, 32'hFFFF_FFFD);
    chk("div_neg7/hi_const", hi, 32'hFFFF_FFFF);
    do_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf/lo_const", lo, 32'h8000_0000);
    do_arith(3'd3, 32'd100, 32'd0, "divu_zero");
    chk("divu_zero/dbz_const", dbz, 1);
    do_mt(3'd4, 32'h0000_0007, "mthi_keeps_dbz");
    do_arith(3'd1, 32'd3, 32'd5, "multu_3x5");
    chk("multu_3x5/lo_const", lo, 32'd15);
    do_arith(3'd2, 32'd7, 32'd0, "div_zero");
    do_arith(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    do_mt(3'd4, 32'hA5A5_A5A5, "mthi");
    do_mt(3'd5, 32'h5A5A_5A5A, "mtlo");
    start = 1'b0;
    do_mt(3'd6, 32'hDEAD_BEEF, "nop6");
    do_mt(3'd7, 32'hCAFE_F00D, "nop7");
    start = 1'b0;

    for (int i = 0; i < 24; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = W'($urandom_range(1, 15));
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_arith(ro, rx, ry, $sformatf("rnd%0d", i));
    end

    // start held high: the next request lands on the first IDLE edge after done
    start = 1'b1; op = 3'd1; x = 32'd3; y = 32'd5;
    @(posedge clk); #1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b/latency1", cyc, W + 1);
    chk("b2b/lo1", lo, 32'd15);
    chk("b2b/idle_at_done", busy, 0);
    @(posedge clk); #1;
    chk("b2b/reaccept", busy, 1);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b/latency2", cyc, W + 1);
    chk("b2b/hi2", hi, 32'd0);
    chk("b2b/lo2", lo, 32'd15);
    m_hi = 32'd0; m_lo = 32'd15; m_dz = 1'b0;
    @(posedge clk); #1;

    // abort: DIVU in flight, MTLO ignored, async reset mid-cycle
    start = 1'b1; op = 3'd3; x = 32'd100; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd5; x = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort/mtlo_ignored", lo, m_lo);
    chk("abort/still_busy", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    chk("abort/busy_before_rst", busy, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/hi", hi, 0);
    chk("abort/lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("abort/no_done", seen, 0);

    do_arith(3'd3, 32'd100, 32'd7, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
